// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory read port and the decode-side valid/ready handshake.
// master = fetch stage, slave = memory + decode environment.
interface ifetch_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_adrs;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;
  logic              ir_valid;
  logic              ir_ready;
  logic [DATA_W-1:0] ir_data;
  logic [ADDR_W-1:0] ir_adrs;

  modport master (
    output mem_req, mem_adrs, ir_valid, ir_data, ir_adrs,
    input  mem_ack, mem_rdata, ir_ready
  );

  modport slave (
    input  mem_req, mem_adrs, ir_valid, ir_data, ir_adrs,
    output mem_ack, mem_rdata, ir_ready
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch: single-outstanding memory read, PC advance on completion, small FIFO to decode.
// Optional memory timeout with sticky fetch_err and ERR state under macro IFETCH_TIMEOUT_EN.
module ifetch #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_adrs,
  output logic              pc_en,
  input  logic              flush,
  output logic              fetch_err,
  ifetch_if.master          bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT == 0) begin : g_param_check
    $error("ifetch: DEPTH must be a power of two >= 2 and TIMEOUT >= 1");
  end

  typedef struct packed {
    logic [ADDR_W-1:0] adrs;
    logic [DATA_W-1:0] data;
  } entry_t;

`ifdef IFETCH_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR = 2'd2} state_e;
  logic [TO_W-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
`else
  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;
`endif

  state_e            state_q, state_d;
  logic              req_q, req_d;
  logic [ADDR_W-1:0] adrs_q, adrs_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  entry_t            fifo_q [DEPTH];
  logic              push, pop;

  assign pc_en        = (state_q == S_WAIT) && bus.mem_ack && !flush;
  assign bus.mem_req  = req_q;
  assign bus.mem_adrs = adrs_q;
  assign bus.ir_valid = (count_q != '0);
  assign bus.ir_data  = fifo_q[rd_ptr_q].data;
  assign bus.ir_adrs  = fifo_q[rd_ptr_q].adrs;
  assign pop          = bus.ir_valid && bus.ir_ready;
  assign count_d      = flush ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);

`ifdef IFETCH_TIMEOUT_EN
  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

  // Next-state logic; flush overrides whatever the current state decided.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    adrs_d  = adrs_q;
    push    = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    err_d   = err_q;
    tmo_d   = tmo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (count_q < CNT_W'(DEPTH)) begin
          state_d = S_WAIT;
          req_d   = 1'b1;
          adrs_d  = pc_adrs;
`ifdef IFETCH_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      S_WAIT: begin
        if (bus.mem_ack) begin
          push    = 1'b1;
          req_d   = 1'b0;
          state_d = S_IDLE;
        end
`ifdef IFETCH_TIMEOUT_EN
        else if (tmo_q == TO_W'(TIMEOUT - 1)) begin
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
`endif
      end
`ifdef IFETCH_TIMEOUT_EN
      S_ERR:   ;
      default: state_d = S_IDLE;
`endif
    endcase
    if (flush) begin
      state_d = S_IDLE;
      req_d   = 1'b0;
      push    = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      req_q    <= 1'b0;
      adrs_q   <= '0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fifo_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      adrs_q  <= adrs_d;
      count_q <= count_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push) begin
          fifo_q[wr_ptr_q] <= '{adrs: adrs_q, data: bus.mem_rdata};
          wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
    end
  end

`ifdef IFETCH_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch stage sitting directly downstream of the program counter. It takes the current PC address, issues a single-outstanding read to instruction memory and advances the PC only when the fetch completes. Fetched words are queued with their addresses in a small FIFO and handed to decode over a valid/ready handshake. A flush input discards in-flight and buffered work on control-flow changes.

## Interface
- `ADDR_W`, default 8: width of PC and memory address.
- `DATA_W`, default 16: instruction word width.
- `DEPTH`, default 2: instruction buffer entries; must be a power of two and at least 2.
- `TIMEOUT`, default 15: maximum WAIT cycles before a fetch error. Used only with `IFETCH_TIMEOUT_EN`.

Ports:
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: asynchronous, active-low reset.
- `pc_adrs`, input, `ADDR_W` bits: current PC value, taken from the PC's `adrs_out`.
- `pc_en`, output, 1 bit: PC advance strobe, driving the PC's `en_pc`.
- `mem_req`, output, 1 bit: memory read request, registered.
- `mem_adrs`, output, `ADDR_W` bits: read address, registered and held while `mem_req` is high.
- `mem_ack`, input, 1 bit: read data valid this cycle.
- `mem_rdata`, input, `DATA_W` bits: read data.
- `flush`, input, 1 bit: synchronous discard of the outstanding fetch and the whole buffer.
- `ir_valid`, output, 1 bit: buffer head is valid.
- `ir_ready`, input, 1 bit: decode accepts the head.
- `ir_data`, output, `DATA_W` bits: head instruction.
- `ir_adrs`, output, `ADDR_W` bits: address of the head instruction.
- `fetch_err`, output, 1 bit: sticky memory timeout flag.

## Operation
- FSM states: IDLE, WAIT, ERR. ERR exists only when `IFETCH_TIMEOUT_EN` is defined.
- **IDLE:** if `!flush` and `count < DEPTH`, go to WAIT, set `mem_req <= 1` and `mem_adrs <= pc_adrs`. Otherwise stay in IDLE with `mem_req` at 0.
- **WAIT:** hold `mem_req` and `mem_adrs`.
  - On `mem_ack && !flush`: push `{mem_adrs, mem_rdata}`, drop `mem_req`, go to IDLE.
  - `pc_en = (state==WAIT) && mem_ack && !flush`. This is combinational and is the only source of `pc_en`.
- Only one fetch is outstanding at a time. WAIT is entered only when the buffer has space, so a push never overflows.
- **Buffer:** circular FIFO with `count` ranging 0..`DEPTH`.
  - `ir_valid = (count != 0)`.
  - A pop occurs on `ir_valid && ir_ready`.
  - A simultaneous push and pop leaves `count` unchanged; the pop takes the old head.
  - `ir_data` and `ir_adrs` are driven from the head entry. Their contents are don't-care while `ir_valid=0`, except that they are 0 after reset.
- **Flush** (any state), at the next edge:
  - `count <= 0`, state goes to IDLE, `mem_req <= 0`, `fetch_err <= 0`.
  - An ack arriving in the same cycle as `flush` is dropped and `pc_en` stays 0.
  - Memory must tolerate a request withdrawn without an ack.
- **Reset** (asynchronous, any time, including mid-fetch):
  - State goes to IDLE; `count`, pointers, `mem_req`, `mem_adrs`, `ir_data`, `ir_adrs` and `fetch_err` all go to 0.
  - `pc_en` is 0 and `ir_valid` is 0.

## Timing
- Zero-wait memory (ack in the first WAIT cycle): one instruction per 2 cycles. `mem_req` rises 1 cycle after IDLE is sampled.
- Latency from IDLE with an empty buffer to `ir_valid`: 2 edges. `ir_valid` rises on the edge after the ack.
- The PC increments on the same edge that captures the data, so `pc_adrs` shows the next address by the following IDLE cycle.
- With `count==DEPTH` and `ir_ready=0`: stay in IDLE with `mem_req=0`. The first pop re-enables a request on the next edge.

## Configuration
- Macro `IFETCH_TIMEOUT_EN`.
- **When defined:**
  - A WAIT cycle counter is cleared on entering WAIT.
  - If `TIMEOUT` cycles elapse without an ack, the block drops `mem_req`, sets `fetch_err` and enters ERR.
  - ERR issues no requests and `pc_en` stays 0. ERR is left only through `flush` (to IDLE, clearing `fetch_err`) or reset.
  - The buffer keeps draining normally while in ERR.
- **When undefined:** WAIT waits indefinitely, `fetch_err` is tied to 0, and ERR is absent.

## Test plan
- **Reset release, zero-wait memory:** `pc_adrs=0x01`, ack with `0xA001`. Expect `ir_valid` with `ir_adrs=0x01`, `ir_data=0xA001`, and one `pc_en` pulse.
- **Backpressure:** `ir_ready=0` over 3 fetches (0x01..0x03). Expect exactly 2 entries buffered, `mem_req=0`, no `pc_en`. Then raise `ir_ready`: expect 0x01 then 0x02 popped, and the fetch of 0x03 resumes.
- **Wait states:** ack delayed 4 cycles. Expect `mem_adrs` stable and `mem_req` high for 4 cycles, with a single `pc_en`.
- **Flush coincident with ack:** 1 entry buffered, then `flush` with `mem_ack`. Expect `ir_valid=0` next cycle, no `pc_en`, and the next request using the current `pc_adrs`.
- **Async reset mid-WAIT:** `rst` low between edges. Expect `mem_req`, `ir_valid` and `fetch_err` at 0 immediately.
- **`IFETCH_TIMEOUT_EN`, no ack for 15 cycles:** expect `fetch_err=1` and `mem_req=0` held. After `flush`, expect `fetch_err=0` and a new request issued.
